// File: rtl/gbc_rtc_target.sv
// MBC3 real-time clock exposed as a pipelined Wishbone target.
// Live counters advance from an internal prescaler; register reads return the latched snapshot.
module gbc_rtc_target #(
  parameter int unsigned TICK_DIV = 4194304
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       stall_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    REG_SEC   = 3'd0,
    REG_MIN   = 3'd1,
    REG_HOUR  = 3'd2,
    REG_DAY   = 3'd3,
    REG_CTL   = 3'd4,
    REG_LATCH = 3'd5
  } regSel_e;

  logic [CW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [8:0]    day_q, day_d;
  logic          halt_q, halt_d, carry_q, carry_d;
  logic [5:0]    lsec_q, lsec_d, lmin_q, lmin_d;
  logic [4:0]    lhour_q, lhour_d;
  logic [8:0]    lday_q, lday_d;
  logic          latchPrev_q, latchPrev_d;
  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;

  logic       accept, wrEn, rdEn;
  logic       wrSec, wrMin, wrHour, wrDay, wrCtl, wrLatch;
  logic       tick, tickEff;
  logic [5:0] secCasc, minCasc;
  logic [4:0] hourCasc;
  logic [8:0] dayCasc;
  logic       secCo, minCo, hourCo, dayOvf;
  logic       minCi, hourCi, dayCi;
  logic [7:0] readData;

  assign accept  = cyc_i & stb_i;
  assign wrEn    = accept & we_i;
  assign rdEn    = accept & ~we_i;
  assign wrSec   = wrEn & (adr_i == REG_SEC);
  assign wrMin   = wrEn & (adr_i == REG_MIN);
  assign wrHour  = wrEn & (adr_i == REG_HOUR);
  assign wrDay   = wrEn & (adr_i == REG_DAY);
  assign wrCtl   = wrEn & (adr_i == REG_CTL);
  assign wrLatch = wrEn & (adr_i == REG_LATCH);

  // A seconds write restarts the prescaler, so it swallows any tick landing on the same edge.
  assign tick    = (presc_q == CNT_MAX) & ~halt_q;
  assign tickEff = tick & ~wrSec;

  always_comb begin
    secCasc  = sec_q;
    secCo    = 1'b0;
    minCasc  = min_q;
    minCo    = 1'b0;
    hourCasc = hour_q;
    hourCo   = 1'b0;
    dayCasc  = day_q;
    dayOvf   = 1'b0;

    if (tickEff) begin
      if (sec_q == 6'd59) begin
        secCasc = '0;
        secCo   = 1'b1;
      end else if (sec_q == 6'd63) begin
        secCasc = '0;
      end else begin
        secCasc = sec_q + 6'd1;
      end
    end

    minCi = secCo & ~wrSec;
    if (minCi) begin
      if (min_q == 6'd59) begin
        minCasc = '0;
        minCo   = 1'b1;
      end else if (min_q == 6'd63) begin
        minCasc = '0;
      end else begin
        minCasc = min_q + 6'd1;
      end
    end

    hourCi = minCo & ~wrMin;
    if (hourCi) begin
      if (hour_q == 5'd23) begin
        hourCasc = '0;
        hourCo   = 1'b1;
      end else if (hour_q == 5'd31) begin
        hourCasc = '0;
      end else begin
        hourCasc = hour_q + 5'd1;
      end
    end

    dayCi = hourCo & ~wrHour;
    if (dayCi) begin
      dayCasc = day_q + 9'd1;
      dayOvf  = (day_q == 9'd511);
    end
  end

  // Written fields override the cascade; the rest advance as though no write happened.
  always_comb begin
    sec_d   = wrSec  ? dat_i[5:0] : secCasc;
    min_d   = wrMin  ? dat_i[5:0] : minCasc;
    hour_d  = wrHour ? dat_i[4:0] : hourCasc;
    day_d   = dayCasc;
    halt_d  = halt_q;
    carry_d = carry_q | (dayOvf & ~wrDay);
    if (wrDay) begin
      day_d[7:0] = dat_i;
    end
    if (wrCtl) begin
      day_d[8] = dat_i[0];
      halt_d   = dat_i[6];
      carry_d  = dat_i[7];
    end

    if (halt_q || wrSec || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    lsec_d      = lsec_q;
    lmin_d      = lmin_q;
    lhour_d     = lhour_q;
    lday_d      = lday_q;
    latchPrev_d = latchPrev_q;
    if (wrLatch) begin
      if (!latchPrev_q && dat_i[0]) begin
        lsec_d  = sec_q;
        lmin_d  = min_q;
        lhour_d = hour_q;
        lday_d  = day_q;
      end
      latchPrev_d = dat_i[0];
    end
  end

  always_comb begin
    readData = 8'hFF;
    case (adr_i)
      REG_SEC:   readData = {2'b00, lsec_q};
      REG_MIN:   readData = {2'b00, lmin_q};
      REG_HOUR:  readData = {3'b000, lhour_q};
      REG_DAY:   readData = lday_q[7:0];
      REG_CTL:   readData = {carry_q, halt_q, 5'b00000, lday_q[8]};
      REG_LATCH: readData = {7'b0000000, latchPrev_q};
      default:   readData = 8'hFF;
    endcase
    ack_d = accept;
    dat_d = rdEn ? readData : 8'h00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      day_q       <= '0;
      halt_q      <= 1'b0;
      carry_q     <= 1'b0;
      lsec_q      <= '0;
      lmin_q      <= '0;
      lhour_q     <= '0;
      lday_q      <= '0;
      latchPrev_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      halt_q      <= halt_d;
      carry_q     <= carry_d;
      lsec_q      <= lsec_d;
      lmin_q      <= lmin_d;
      lhour_q     <= lhour_d;
      lday_q      <= lday_d;
      latchPrev_q <= latchPrev_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign stall_o = 1'b0;

endmodule

// File: tb/tb_gbc_rtc_target.sv
// Directed bench for gbc_rtc_target with a 4-cycle second; requests driven and sampled on falling edges.
module tb_gbc_rtc_target;

  logic       clk;
  logic       rstN;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [2:0] adr;
  logic [7:0] datIn;
  logic [7:0] datOut;
  logic       ack;
  logic       stall;

  int checks = 0;
  int errors = 0;

  gbc_rtc_target #(.TICK_DIV(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (datIn),
    .dat_o   (datOut),
    .ack_o   (ack),
    .stall_o (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 'h%02h, expected 'h%02h", tag, observed, expected);
    end
  endtask

  // One request per call: presented at a falling edge, accepted on the next rising edge.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] rd);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    adr   = a;
    datIn = d;
    @(negedge clk);
    checkOutput($sformatf("ack adr%0d", a), {7'b0, ack}, 8'h01);
    rd  = datOut;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] ignored;
    applyStimulus(1'b1, a, d, ignored);
  endtask

  task automatic readCheck(input string tag, input logic [2:0] a, input logic [7:0] expected);
    logic [7:0] rd;
    applyStimulus(1'b0, a, 8'h00, rd);
    checkOutput(tag, rd, expected);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("ack idle", {7'b0, ack}, 8'h00);
    end
  endtask

  initial begin
    rstN  = 1'b0;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    adr   = 3'd0;
    datIn = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset ack", {7'b0, ack}, 8'h00);
    checkOutput("reset dat", datOut, 8'h00);
    checkOutput("stall", {7'b0, stall}, 8'h00);
    rstN = 1'b1;

    // Capture a non-zero snapshot, then reset in the middle of a read response.
    writeReg(3'd0, 8'd30);
    writeReg(3'd5, 8'h01);
    readCheck("pre-reset sec", 3'd0, 8'd30);
    cyc = 1'b1;
    stb = 1'b1;
    we  = 1'b0;
    adr = 3'd0;
    @(posedge clk);
    #2;
    checkOutput("ack before reset", {7'b0, ack}, 8'h01);
    checkOutput("dat before reset", datOut, 8'd30);
    rstN = 1'b0;
    #1;
    checkOutput("ack async reset", {7'b0, ack}, 8'h00);
    checkOutput("dat async reset", datOut, 8'h00);
    cyc = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    readCheck("reset sec", 3'd0, 8'h00);
    readCheck("reset min", 3'd1, 8'h00);
    readCheck("reset hour", 3'd2, 8'h00);
    readCheck("reset day", 3'd3, 8'h00);
    readCheck("reset ctl", 3'd4, 8'h00);
    readCheck("reset latch", 3'd5, 8'h00);
    readCheck("unused adr7", 3'd7, 8'hFF);
    idle(1);

    // Full rollover: tick lands 4 edges after the unhalting ADR4 write.
    writeReg(3'd4, 8'h40);
    writeReg(3'd0, 8'd59);
    writeReg(3'd1, 8'd59);
    writeReg(3'd2, 8'd23);
    writeReg(3'd3, 8'hFF);
    writeReg(3'd4, 8'h01);
    writeReg(3'd5, 8'h00);
    idle(3);
    writeReg(3'd5, 8'h01);
    readCheck("roll sec", 3'd0, 8'h00);
    readCheck("roll min", 3'd1, 8'h00);
    readCheck("roll hour", 3'd2, 8'h00);
    readCheck("roll day", 3'd3, 8'h00);
    readCheck("roll ctl", 3'd4, 8'h80);

    // Out-of-range seconds wrap without carrying into minutes.
    writeReg(3'd4, 8'h40);
    writeReg(3'd0, 8'd63);
    writeReg(3'd1, 8'd5);
    writeReg(3'd4, 8'h00);
    writeReg(3'd5, 8'h00);
    idle(3);
    writeReg(3'd5, 8'h01);
    readCheck("wrap sec", 3'd0, 8'h00);
    readCheck("wrap min", 3'd1, 8'd5);
    readCheck("wrap ctl", 3'd4, 8'h00);

    // Halt freezes the clock; unhalting gives exactly one tick after 4 edges.
    writeReg(3'd4, 8'h40);
    writeReg(3'd0, 8'd10);
    idle(40);
    writeReg(3'd5, 8'h00);
    writeReg(3'd5, 8'h01);
    readCheck("halt sec", 3'd0, 8'd10);
    readCheck("halt ctl", 3'd4, 8'h40);
    writeReg(3'd4, 8'h00);
    writeReg(3'd5, 8'h00);
    writeReg(3'd5, 8'h01);
    readCheck("unhalt sec early", 3'd0, 8'd10);
    writeReg(3'd5, 8'h00);
    writeReg(3'd5, 8'h01);
    readCheck("unhalt sec +1", 3'd0, 8'd11);

    // A repeated 1 is not a 0->1 edge, so the snapshot must not move.
    writeReg(3'd5, 8'h01);
    idle(8);
    writeReg(3'd5, 8'h01);
    idle(2);
    readCheck("latch hold sec", 3'd0, 8'd11);
    readCheck("latch prev", 3'd5, 8'h01);
    writeReg(3'd5, 8'h00);
    writeReg(3'd5, 8'h01);
    readCheck("latch new sec", 3'd0, 8'd15);

    // Minutes write on the 59->0 tick: written value wins and hour sees no carry.
    writeReg(3'd4, 8'h40);
    writeReg(3'd0, 8'd59);
    writeReg(3'd1, 8'd59);
    writeReg(3'd2, 8'd5);
    writeReg(3'd4, 8'h00);
    idle(3);
    writeReg(3'd1, 8'h2A);
    readCheck("pipelined adr6", 3'd6, 8'hFF);
    idle(1);
    writeReg(3'd5, 8'h00);
    writeReg(3'd5, 8'h01);
    readCheck("collide sec", 3'd0, 8'h00);
    readCheck("collide min", 3'd1, 8'h2A);
    readCheck("collide hour", 3'd2, 8'd5);

    // Without CYC the strobe must be ignored.
    stb = 1'b1;
    we  = 1'b0;
    adr = 3'd0;
    @(negedge clk);
    checkOutput("no cyc ack", {7'b0, ack}, 8'h00);
    stb = 1'b0;
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
